// File: rtl/sys_defs.sv
// Shared machine-wide types: physical tag, data word, writeback lane count
// and the tag/data packet carried on the common data bus.
package sys_defs;

  localparam int N          = 2;
  localparam int PHYS_TAG_W = 6;
  localparam int DATA_W     = 32;

  typedef logic [PHYS_TAG_W-1:0] PHYS_TAG;
  typedef logic [DATA_W-1:0]     DATA;

  typedef struct packed {
    PHYS_TAG tag;
    DATA     data;
  } WB_PACKET;

endpackage

// File: rtl/wb_skid_fifo.sv
// Two-entry result queue in front of the writeback arbiter. The caller only
// pushes when occupancy < 2 and only pops when occupancy > 0.
module wb_skid_fifo
  import sys_defs::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       flush,
  input  logic       push,
  input  logic       pop,
  input  WB_PACKET   push_pkt,
  output WB_PACKET   head_pkt,
  output logic [1:0] occupancy
);

  WB_PACKET   mem_q [2];
  WB_PACKET   mem_d [2];
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_pkt;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      // Simultaneous push and pop leave the count unchanged.
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_pkt  = mem_q[rd_ptr_q];
  assign occupancy = count_q;

endmodule

// File: rtl/cdb_writeback.sv
// Collects results from NUM_SRC functional units into per-source queues and
// round-robin packs up to N of them per cycle onto the registered writeback lanes.
module cdb_writeback
  import sys_defs::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic [NUM_SRC-1:0]   src_valid,
  input  PHYS_TAG [NUM_SRC-1:0] src_tag,
  input  DATA [NUM_SRC-1:0]    src_data,
  output logic [NUM_SRC-1:0]   src_ready,
  output logic [N-1:0]         wb_en,
  output PHYS_TAG [N-1:0]      wb_idx,
  output DATA [N-1:0]          wb_data
);

  localparam int RR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  WB_PACKET           in_pkt    [NUM_SRC];
  WB_PACKET           head      [NUM_SRC];
  logic [1:0]         occupancy [NUM_SRC];
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] grant;

  logic [RR_W-1:0]    rr_q, rr_d;
  logic [N-1:0]       wb_en_q, wb_en_d;
  PHYS_TAG [N-1:0]    wb_idx_q, wb_idx_d;
  DATA [N-1:0]        wb_data_q, wb_data_d;

  int lane;
  int src;

  // Tag 0 is the "no destination" tag: the beat is accepted but never queued.
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign src_ready[gi] = reset_n && (occupancy[gi] < 2'd2);
      assign push[gi]      = src_valid[gi] && src_ready[gi] && !flush
                             && (src_tag[gi] != '0);
      assign in_pkt[gi]    = {src_tag[gi], src_data[gi]};

      wb_skid_fifo u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .push      (push[gi]),
        .pop       (grant[gi]),
        .push_pkt  (in_pkt[gi]),
        .head_pkt  (head[gi]),
        .occupancy (occupancy[gi])
      );
    end
  endgenerate

  // Scan from rr, handing the k-th non-empty source to lane k.
  always_comb begin
    grant     = '0;
    wb_en_d   = '0;
    wb_idx_d  = '0;
    wb_data_d = '0;
    rr_d      = rr_q;
    lane      = 0;
    src       = 0;
    if (!flush) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        src = int'(rr_q) + k;
        if (src >= NUM_SRC) begin
          src = src - NUM_SRC;
        end
        if ((occupancy[src] != 2'd0) && (lane < N)) begin
          grant[src]      = 1'b1;
          wb_en_d[lane]   = 1'b1;
          wb_idx_d[lane]  = head[src].tag;
          wb_data_d[lane] = head[src].data;
          rr_d            = RR_W'((src + 1) % NUM_SRC);
          lane            = lane + 1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_q      <= '0;
      wb_en_q   <= '0;
      wb_idx_q  <= '0;
      wb_data_q <= '0;
    end else begin
      rr_q      <= rr_d;
      wb_en_q   <= wb_en_d;
      wb_idx_q  <= wb_idx_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign wb_en   = wb_en_q;
  assign wb_idx  = wb_idx_q;
  assign wb_data = wb_data_q;

endmodule

// File: tb/tb_cdb_writeback.sv
// Directed bench for cdb_writeback with N=2 lanes and four sources; expected
// lane contents are worked out by hand for each step.
module tb_cdb_writeback;
  import sys_defs::*;

  logic            clock;
  logic            reset_n;
  logic            flush;
  logic [3:0]      src_valid;
  PHYS_TAG [3:0]   src_tag;
  DATA [3:0]       src_data;
  logic [3:0]      src_ready;
  logic [N-1:0]    wb_en;
  PHYS_TAG [N-1:0] wb_idx;
  DATA [N-1:0]     wb_data;

  int checks = 0;
  int errors = 0;

  cdb_writeback #(.NUM_SRC(4)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (flush),
    .src_valid (src_valid),
    .src_tag   (src_tag),
    .src_data  (src_data),
    .src_ready (src_ready),
    .wb_en     (wb_en),
    .wb_idx    (wb_idx),
    .wb_data   (wb_data)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (wb_en != '0)
      $display("t=%0t wb en=%b lane0 tag=%0d data=%h lane1 tag=%0d data=%h",
               $time, wb_en, wb_idx[0], wb_data[0], wb_idx[1], wb_data[1]);
  endtask

  task automatic set_src(input int s, input PHYS_TAG t, input DATA d);
    src_valid[s] = 1'b1;
    src_tag[s]   = t;
    src_data[s]  = d;
  endtask

  task automatic idle();
    src_valid = '0;
  endtask

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    src_valid = '0;
    src_tag   = '0;
    src_data  = '0;

    // Reset state
    #2;
    chk("rst_wb_en", wb_en, 0);
    chk("rst_ready", src_ready, 0);
    chk("rst_wb_idx", wb_idx, 0);
    chk("rst_wb_data", wb_data, 0);
    tick();
    chk("rst_ready_held", src_ready, 0);
    #2 reset_n = 1'b1;
    #1 chk("rel_ready", src_ready, 4'hF);

    // Single result: accepted at edge 1, visible after edge 2
    set_src(0, 6'd5, 32'hAA);
    tick(); idle();
    chk("single_no_bypass", wb_en, 2'b00);
    tick();
    chk("single_en", wb_en, 2'b01);
    chk("single_idx", wb_idx[0], 5);
    chk("single_data", wb_data[0], 32'hAA);
    tick();
    chk("single_one_cycle", wb_en, 2'b00);

    // rr is 1 now; a grant of src3 wraps it back to 0
    set_src(3, 6'd7, 32'h33);
    tick(); idle();
    tick();
    chk("wrap_en", wb_en, 2'b01);
    chk("wrap_idx", wb_idx[0], 7);
    tick();

    // All four sources at once with rr=0
    for (int s = 0; s < 4; s++) set_src(s, PHYS_TAG'(s + 1), DATA'(32'h100 + s + 1));
    tick(); idle();
    chk("all4_latency", wb_en, 2'b00);
    tick();
    chk("all4_a_en", wb_en, 2'b11);
    chk("all4_a_idx0", wb_idx[0], 1);
    chk("all4_a_idx1", wb_idx[1], 2);
    chk("all4_a_data1", wb_data[1], 32'h102);
    tick();
    chk("all4_b_en", wb_en, 2'b11);
    chk("all4_b_idx0", wb_idx[0], 3);
    chk("all4_b_idx1", wb_idx[1], 4);
    chk("all4_b_data0", wb_data[0], 32'h103);
    tick();
    chk("all4_drained", wb_en, 2'b00);
    // rr must be 0: src0 wins lane 0 over src1
    set_src(0, 6'd9, 32'h9);
    set_src(1, 6'd10, 32'hA);
    tick(); idle();
    tick();
    chk("rr0_idx0", wb_idx[0], 9);
    chk("rr0_idx1", wb_idx[1], 10);
    tick();

    // Backpressure on src1 (rr=2, src2/src3 take the lanes first)
    set_src(0, 6'd21, 32'h21); set_src(1, 6'd11, 32'h11);
    set_src(2, 6'd31, 32'h31); set_src(3, 6'd41, 32'h41);
    tick();
    chk("bp_ready_e1", src_ready, 4'hF);
    set_src(0, 6'd22, 32'h22); set_src(1, 6'd12, 32'h12);
    set_src(2, 6'd32, 32'h32); set_src(3, 6'd42, 32'h42);
    tick();
    chk("bp_e2_idx0", wb_idx[0], 31);
    chk("bp_e2_idx1", wb_idx[1], 41);
    chk("bp_ready_full", src_ready, 4'b1100);
    idle();
    set_src(1, 6'd13, 32'h13);
    tick();
    chk("bp_e3_idx0", wb_idx[0], 21);
    chk("bp_e3_idx1", wb_idx[1], 11);
    chk("bp_ready_e3", src_ready, 4'hF);
    tick(); idle();
    chk("bp_e4_idx0", wb_idx[0], 32);
    chk("bp_e4_idx1", wb_idx[1], 42);
    tick();
    chk("bp_e5_idx0", wb_idx[0], 22);
    chk("bp_e5_idx1", wb_idx[1], 12);
    tick();
    chk("bp_e6_en", wb_en, 2'b01);
    chk("bp_e6_idx0", wb_idx[0], 13);
    chk("bp_e6_data0", wb_data[0], 32'h13);
    tick();
    chk("bp_done", wb_en, 2'b00);

    // Tag 0 is accepted and dropped
    set_src(2, 6'd0, 32'h55);
    chk("tag0_ready", src_ready[2], 1'b1);
    tick(); idle();
    chk("tag0_en_a", wb_en, 2'b00);
    chk("tag0_ready_after", src_ready, 4'hF);
    tick();
    chk("tag0_en_b", wb_en, 2'b00);
    tick();
    chk("tag0_en_c", wb_en, 2'b00);

    // Flush with queued entries (rr=2)
    for (int s = 0; s < 4; s++) set_src(s, PHYS_TAG'(s + 1), DATA'(32'h200 + s + 1));
    tick();
    for (int s = 0; s < 4; s++) set_src(s, PHYS_TAG'(s + 5), DATA'(32'h200 + s + 5));
    tick(); idle();
    chk("fl_pre_idx0", wb_idx[0], 3);
    chk("fl_pre_idx1", wb_idx[1], 4);
    flush = 1'b1;
    set_src(0, 6'd50, 32'h50);
    tick(); idle();
    flush = 1'b0;
    chk("fl_en", wb_en, 2'b00);
    chk("fl_ready", src_ready, 4'hF);
    tick();
    chk("fl_empty", wb_en, 2'b00);
    // rr kept at 0 through the flush: src0 leads src2
    set_src(0, 6'd6, 32'h6);
    set_src(2, 6'd7, 32'h7);
    tick(); idle();
    tick();
    chk("fl_rr_idx0", wb_idx[0], 6);
    chk("fl_rr_idx1", wb_idx[1], 7);
    tick();

    // Asynchronous reset mid-stream (rr=3)
    for (int s = 0; s < 4; s++) set_src(s, PHYS_TAG'(s + 11), DATA'(32'h300 + s + 11));
    tick(); idle();
    tick();
    chk("ar_pre_en", wb_en, 2'b11);
    chk("ar_pre_idx0", wb_idx[0], 14);
    chk("ar_pre_idx1", wb_idx[1], 11);
    #3 reset_n = 1'b0;
    #1;
    chk("ar_en", wb_en, 2'b00);
    chk("ar_ready", src_ready, 4'h0);
    chk("ar_idx", wb_idx, 0);
    tick();
    chk("ar_en_held", wb_en, 2'b00);
    #2 reset_n = 1'b1;
    #1 chk("ar_rel_ready", src_ready, 4'hF);
    set_src(0, 6'd30, 32'h30);
    set_src(3, 6'd33, 32'h33);
    tick(); idle();
    chk("ar_latency", wb_en, 2'b00);
    tick();
    chk("ar_post_en", wb_en, 2'b11);
    chk("ar_post_idx0", wb_idx[0], 30);
    chk("ar_post_idx1", wb_idx[1], 33);
    tick();
    chk("ar_post_drained", wb_en, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_writeback.md
CDB_WRITEBACK -- requirements
Module: cdb_writeback

Interface
REQ-001 The block SHALL have parameter NUM_SRC, default 4, meaning the number of functional-unit result sources; legal values are NUM_SRC >= `N.
REQ-002 The block SHALL have port clock, input, 1 bit: the rising-edge clock.
REQ-003 The block SHALL have port reset_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 The block SHALL have port flush, input, 1 bit: mispredict squash.
REQ-005 The block SHALL have port src_valid, input, [NUM_SRC]: the result is offered by source s.
REQ-006 The block SHALL have port src_tag, input, PHYS_TAG [NUM_SRC]: the destination physical tag.
REQ-007 The block SHALL have port src_data, input, DATA [NUM_SRC]: the result value.
REQ-008 The block SHALL have port src_ready, output, [NUM_SRC]: source s may hand over a result this cycle.
REQ-009 The block SHALL have port wb_en, output, [`N]: the writeback lane is valid; it drives the register file write_en.
REQ-010 The block SHALL have port wb_idx, output, PHYS_TAG [`N]: the lane tag; it drives write_idx and the CDB broadcast.
REQ-011 The block SHALL have port wb_data, output, DATA [`N]: the lane value; it drives write_data.

Function
REQ-012 A transfer on source s SHALL occur at a rising edge where src_valid[s] && src_ready[s]; src_valid has no other meaning.
REQ-013 Each source SHALL own a 2-entry FIFO; src_ready[s] = (occupancy[s] < 2) at cycle start, so a full FIFO never accepts, even while popping that cycle.
REQ-014 A transfer with src_tag == 0 SHALL be accepted (ready honoured) and discarded: no enqueue, no writeback.
REQ-015 Each cycle a round-robin arbiter SHALL grant up to `N non-empty FIFOs, scanning s = rr, rr+1, ... mod NUM_SRC; the k-th grant goes to lane k (lanes packed from 0).
REQ-016 Granted FIFO heads SHALL pop at the next edge, and wb_en/wb_idx/wb_data SHALL be registered at that same edge; lanes without a grant SHALL have wb_en=0 and wb_idx/wb_data=0.
REQ-017 Latency: a result accepted at edge t SHALL appear on wb_* at the earliest after edge t+1 (valid for one cycle); the FIFO is never bypassed.
REQ-018 rr SHALL advance to (last granted source + 1) mod NUM_SRC at the edge; with no grant, rr holds; the pointer wraps from NUM_SRC-1 to 0.
REQ-019 Per-source FIFO order SHALL be preserved; no ordering is promised across sources.
REQ-020 At most one lane per cycle SHALL carry a given source; distinct sources carrying equal tags is illegal upstream and is not checked.
REQ-021 flush=1 at an edge SHALL empty all FIFOs, discard that edge's transfers, and force wb_en=0 for the following cycle; rr is unchanged.
REQ-022 A flush asserted on consecutive cycles SHALL keep everything empty; src_ready stays 1 during flush (accepted beats are dropped).
REQ-023 Occupancy counters SHALL be 2 bits with saturation impossible by construction; push and pop in the same cycle keeps occupancy unchanged.

Reset
REQ-024 While reset_n=0 the block SHALL empty all FIFOs, set rr=0, drive wb_en=0, wb_idx=0, wb_data=0, and force src_ready=0.
REQ-025 Reset SHALL take effect immediately (asynchronously) mid-operation, discarding in-flight results with no partial writeback.
REQ-026 The first acceptance after reset SHALL be possible at the first rising edge with reset_n=1.

Structure
REQ-027 PHYS_TAG, DATA, `N and a new WB_PACKET struct {PHYS_TAG tag; DATA data} SHALL live in the shared sys_defs package.
REQ-028 The per-source queue SHALL be a sub-module wb_skid_fifo (2-entry, push/pop/flush, occupancy out), instantiated NUM_SRC times.
REQ-029 The arbiter and output registers SHALL be inline in cdb_writeback.

Verification (N=2, NUM_SRC=4)
REQ-030 The bench SHALL cover: src0 tag 5 data 0xAA at edge 1 -> wb_en[0]=1, wb_idx[0]=5, wb_data[0]=0xAA in the cycle after edge 2; wb_en[1]=0.
REQ-031 The bench SHALL cover: all 4 sources valid at one edge (tags 1-4), rr=0 -> lanes carry tags 1,2 then tags 3,4 on the next cycle; rr ends at 0.
REQ-032 The bench SHALL cover: src1 pushed 3 cycles back-to-back with no grants (other sources preloaded) -> src_ready[1]=0 after 2 entries, and the 3rd beat is held by the source.
REQ-033 The bench SHALL cover: tag-0 transfer on src2 -> src_ready honoured, and wb_en stays 0 throughout.
REQ-034 The bench SHALL cover: 4 entries queued, then flush for 1 cycle -> wb_en=0 on the next cycle, all FIFOs empty, and src_ready all 1.
REQ-035 The bench SHALL cover: reset_n dropped mid-stream between edges -> wb_en=0 and src_ready=0 immediately; after release, the first new result emerges with rr=0 ordering.
